ula_arbiter: RTL

- Two-requester arbiter and sequencer for the shared ALU (op encoding 00 add, 01 sub, 10 and, 11 or).
- Accepts one command at a time from either requester over a valid/ready channel, using round-robin arbitration.
- Drives the ALU's op/a/b inputs and holds them stable for the ALU latency, then captures result and v/c/n/z flags.
- Returns the captured result on a single tagged response channel.
- Sits between the datapath clients and the ALU, which is registered on clk.

---
 rtl/ula_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ula_arbiter.sv
// Round-robin front end for the shared registered ALU: accepts one command from
// either of two requesters, holds the ALU inputs for ALU_LAT edges, and returns a tagged response.
module ula_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_v,
    input  logic             alu_c,
    input  logic             alu_n,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid must not depend on ready, and the producer holds its payload until the transfer.

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          grant;
    logic          grant_vld;
    logic          accept;
    logic          capture;
    logic          rsp_done;

    // Round-robin: on contention the requester that did not win last time goes next.
    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (req0_valid && req1_valid) begin
            grant     = ~last_grant;
            grant_vld = 1'b1;
        end else if (req0_valid) begin
            grant     = 1'b0;
            grant_vld = 1'b1;
        end else if (req1_valid) begin
            grant     = 1'b1;
            grant_vld = 1'b1;
        end
    end

    assign accept   = (state == IDLE) && grant_vld;
    assign capture  = (state == EXEC) && (cnt == '0);
    assign rsp_done = (state == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)   state_nx = EXEC;
            EXEC:    if (capture)  state_nx = RESP;
            RESP:    if (rsp_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = (state != IDLE);
        if (state == IDLE && grant_vld) begin
            req0_ready = ~grant;
            req1_ready = grant;
        end
    end

    // ALU operands change only on an accept edge, so the ALU sees them stable through capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept) begin
                alu_op     <= grant ? req1_op : req0_op;
                alu_a      <= grant ? req1_a  : req0_a;
                alu_b      <= grant ? req1_b  : req0_b;
                rsp_id     <= grant;
                last_grant <= grant;
                cnt        <= CW'(ALU_LAT);
            end
            if (state == EXEC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_v, alu_c, alu_n, alu_z};
                rsp_valid  <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
